// File: rtl/seg_display_ctrl.sv
// Score display sequencer: source select, multi-cycle binary-to-BCD conversion, 4-digit scan.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_display_ctrl #(
    parameter int SCAN_DIV = 65536,
    parameter int ALT_DIV  = 50000000,
    parameter int MAX_VAL  = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] score,
    input  logic        score_vld,
    input  logic [13:0] hiscore,
    input  logic        game_over,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        show_hi,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int ALT_W  = $clog2(ALT_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [ALT_W-1:0]  ALT_LAST  = ALT_W'(ALT_DIV - 1);
    localparam logic [13:0]       MAX_V     = 14'(MAX_VAL);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2
    } conv_state_e;

    // ---------------- source select ----------------
    logic [ALT_W-1:0] alt_cnt_q, alt_cnt_d;
    logic             show_hi_q, show_hi_d;
    logic             alt_wrap;
    logic             req;
    logic [13:0]      src_raw;
    logic [13:0]      src_clamped;

    always_comb begin
        alt_wrap  = game_over && (alt_cnt_q == ALT_LAST);
        alt_cnt_d = '0;
        show_hi_d = 1'b0;
        if (game_over) begin
            alt_cnt_d = alt_wrap ? '0 : alt_cnt_q + 1'b1;
            show_hi_d = show_hi_q ^ alt_wrap;
        end
        // Leaving game-over while the high score is up must restore the score.
        req         = (score_vld && !show_hi_q) || alt_wrap || (!game_over && show_hi_q);
        src_raw     = show_hi_d ? hiscore : score;
        src_clamped = (src_raw > MAX_V) ? MAX_V : src_raw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alt_cnt_q <= '0;
            show_hi_q <= 1'b0;
        end else begin
            alt_cnt_q <= alt_cnt_d;
            show_hi_q <= show_hi_d;
        end
    end

    // ---------------- BCD conversion ----------------
    conv_state_e state_q;
    logic [13:0] bin_q;
    logic [15:0] sh_q;
    logic [15:0] sh_adj;
    logic [3:0]  iter_q;
    logic        pending_q;
    logic        busy_q;
    logic [15:0] disp_q;

    always_comb begin
        sh_adj = sh_q;
        for (int n = 0; n < 4; n++) begin
            if (sh_q[n*4 +: 4] >= 4'd5) begin
                sh_adj[n*4 +: 4] = sh_q[n*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bin_q     <= '0;
            sh_q      <= '0;
            iter_q    <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            disp_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        bin_q   <= src_clamped;
                        sh_q    <= '0;
                        iter_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (req) begin
                        pending_q <= 1'b1;
                    end
                    sh_q   <= {sh_adj[14:0], bin_q[13]};
                    bin_q  <= {bin_q[12:0], 1'b0};
                    iter_q <= iter_q + 4'd1;
                    if (iter_q == 4'd13) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    disp_q <= sh_q;
                    // A request seen while converting restarts at once with the latest source.
                    if (pending_q || req) begin
                        pending_q <= 1'b0;
                        bin_q     <= src_clamped;
                        sh_q      <= '0;
                        iter_q    <= '0;
                        state_q   <= ST_CONV;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ---------------- digit scan ----------------
    logic [SCAN_W-1:0] scan_cnt_q;
    logic [1:0]        idx_q;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        an_q, an_d;
    logic [3:0]        nib;
    logic              blank;

    function automatic logic [6:0] decode7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    always_comb begin
        nib   = disp_q[{idx_q, 2'b00} +: 4];
        blank = 1'b0;
`ifdef SEG_LZ_BLANK_EN
        case (idx_q)
            2'd3:    blank = (disp_q[15:12] == 4'd0);
            2'd2:    blank = (disp_q[15:8] == 8'd0);
            2'd1:    blank = (disp_q[15:4] == 12'd0);
            default: blank = 1'b0;
        endcase
`endif
        seg_d = blank ? 7'h7F : decode7(nib);
        an_d  = ~(4'b0001 << idx_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
            seg_q      <= 7'h7F;
            an_q       <= 4'hF;
        end else if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_q <= '0;
            idx_q      <= idx_q + 2'd1;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign show_hi   = show_hi_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule
